// File: rtl/draw_point_fb_writer.sv
// ---------------------------------------------------------------------------
// draw_point_fb_writer
//
// Receives DrawPoint strobes, range-checks each point against the frame size,
// queues the points that are in range in a small FIFO and turns each queued
// point into a single-beat Avalon-MM write to frame-buffer memory.
//
// Ports
//   csi_clock_clk          block clock
//   rsi_reset_reset        synchronous reset, active-high
//   coe_dps_ul1Update      one-cycle strobe: point valid
//   coe_dps_ul9PosX/PosY   point coordinates
//   coe_dps_ul12Rgb12Data  pixel colour
//   coe_clear_counters     synchronous clear of both counters
//   avm_fb_*               Avalon-MM write master (word addressed, 16-bit data)
//   ul16DropCount          out-of-range points, saturating
//   ul16OverflowCount      points lost to a full FIFO, saturating
//   ul1Busy                FIFO non-empty or a write in progress
// ---------------------------------------------------------------------------
module draw_point_fb_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int FB_BASE    = 0,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              csi_clock_clk,
  input  logic              rsi_reset_reset,
  input  logic              coe_dps_ul1Update,
  input  logic [8:0]        coe_dps_ul9PosX,
  input  logic [8:0]        coe_dps_ul9PosY,
  input  logic [11:0]       coe_dps_ul12Rgb12Data,
  input  logic              coe_clear_counters,
  output logic [ADDR_W-1:0] avm_fb_address,
  output logic              avm_fb_write,
  output logic [15:0]       avm_fb_writedata,
  output logic [1:0]        avm_fb_byteenable,
  input  logic              avm_fb_waitrequest,
  output logic [15:0]       ul16DropCount,
  output logic [15:0]       ul16OverflowCount,
  output logic              ul1Busy
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 30;  // {x[8:0], y[8:0], rgb[11:0]}

  localparam logic [31:0] WIDTH_U  = 32'(FB_WIDTH);
  localparam logic [31:0] HEIGHT_U = 32'(FB_HEIGHT);

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic [15:0]         drop_q, drop_d;
  logic [15:0]         ovf_q, ovf_d;
  logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];

  logic                in_range;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head;
  logic [8:0]          head_x;
  logic [8:0]          head_y;
  logic [11:0]         head_rgb;
  logic [ADDR_W-1:0]   head_addr;

  always_comb begin
    in_range   = (32'(coe_dps_ul9PosX) < WIDTH_U) && (32'(coe_dps_ul9PosY) < HEIGHT_U);
    // Fullness is judged on the count at the start of the cycle, so a pop in
    // the same cycle never makes room for the incoming point.
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    push       = coe_dps_ul1Update && in_range && !fifo_full;
    push_entry = {coe_dps_ul9PosX, coe_dps_ul9PosY, coe_dps_ul12Rgb12Data};

    head       = fifo_mem_q[rd_ptr_q];
    head_x     = head[29:21];
    head_y     = head[20:12];
    head_rgb   = head[11:0];
    // Modular arithmetic in ADDR_W bits gives the same LSBs as a full-width
    // sum truncated afterwards; the multiply is by a constant.
    head_addr  = ADDR_W'(FB_BASE) + ADDR_W'(head_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(head_x);
  end

  // Next-state / datapath
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!avm_fb_waitrequest) begin
          // Beat completes; chain straight into the next entry if one waits.
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      addr_d   = head_addr;
      data_d   = {4'h0, head_rgb};
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Range check has priority over the full check.
    if (coe_dps_ul1Update) begin
      if (!in_range) begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else if (fifo_full) begin
        if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
      end
    end
    if (coe_clear_counters) begin
      drop_d = '0;
      ovf_d  = '0;
    end
  end

  always_ff @(posedge csi_clock_clk) begin
    if (rsi_reset_reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge csi_clock_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign avm_fb_address    = addr_q;
  assign avm_fb_write      = (state_q == ST_WRITE);
  assign avm_fb_writedata  = data_q;
  assign avm_fb_byteenable = 2'b11;
  assign ul16DropCount     = drop_q;
  assign ul16OverflowCount = ovf_q;
  assign ul1Busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_draw_point_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_draw_point_fb_writer
//
// Directed bench for draw_point_fb_writer: one task per scenario, each with
// hand-computed expectations. A monitor records every completed Avalon beat
// (address, data, cycle) for ordering and gap checks.
// ---------------------------------------------------------------------------
module tb_draw_point_fb_writer;

  logic        clk;
  logic        srst;
  logic        upd;
  logic [8:0]  px;
  logic [8:0]  py;
  logic [11:0] rgb;
  logic        clr;
  logic        waitreq;
  logic [16:0] addr;
  logic        wr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic [15:0] drop;
  logic [15:0] ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [16:0] beat_addr [$];
  logic [15:0] beat_data [$];
  int          beat_cyc  [$];

  draw_point_fb_writer dut (
    .csi_clock_clk         (clk),
    .rsi_reset_reset       (srst),
    .coe_dps_ul1Update     (upd),
    .coe_dps_ul9PosX       (px),
    .coe_dps_ul9PosY       (py),
    .coe_dps_ul12Rgb12Data (rgb),
    .coe_clear_counters    (clr),
    .avm_fb_address        (addr),
    .avm_fb_write          (wr),
    .avm_fb_writedata      (wdata),
    .avm_fb_byteenable     (be),
    .avm_fb_waitrequest    (waitreq),
    .ul16DropCount         (drop),
    .ul16OverflowCount     (ovf),
    .ul1Busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (wr && !waitreq) begin
      beat_addr.push_back(addr);
      beat_data.push_back(wdata);
      beat_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_point(input int x, input int y, input int c);
    upd = 1'b1;
    px  = 9'(x);
    py  = 9'(y);
    rgb = 12'(c);
    tick();
    upd = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1; upd = 1'b0; px = '0; py = '0; rgb = '0; clr = 1'b0; waitreq = 1'b0;
    repeat (3) tick();
    srst = 1'b0;
    tick();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", wr); end
    checks++; if (addr !== 17'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
    checks++; if (wdata !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", wdata); end
    checks++; if (be !== 2'b11) begin errors++; $display("FAIL reset_be got %b want 11", be); end
    checks++; if (drop !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop); end
    checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL reset_ovf got %0d want 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int base;
    base = beat_addr.size();
    waitreq = 1'b0;
    drive_point(10, 5, 12'hABC);               // now in N+1
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_n1_write got %b want 0", wr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_n1_busy got %b want 1", busy); end
    tick();                                    // N+2
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL single_n2_write got %b want 1", wr); end
    checks++; if (addr !== 17'd1610) begin errors++; $display("FAIL single_addr got %0d want 1610", addr); end
    checks++; if (wdata !== 16'h0ABC) begin errors++; $display("FAIL single_data got %h want 0abc", wdata); end
    checks++; if (be !== 2'b11) begin errors++; $display("FAIL single_be got %b want 11", be); end
    tick();                                    // N+3
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_n3_write got %b want 0", wr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_n3_busy got %b want 0", busy); end
    checks++; if (beat_addr.size() - base !== 1) begin errors++; $display("FAIL single_beats got %0d want 1", beat_addr.size() - base); end
    $display("test_single: addr=%0d data=%h", beat_addr[base], beat_data[base]);
  endtask

  task automatic test_boundary();
    waitreq = 1'b0;
    drive_point(319, 239, 12'hFFF);
    tick();
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL corner_write got %b want 1", wr); end
    checks++; if (addr !== 17'd76799) begin errors++; $display("FAIL corner_addr got %0d want 76799", addr); end
    checks++; if (wdata !== 16'h0FFF) begin errors++; $display("FAIL corner_data got %h want 0fff", wdata); end
    tick();
    checks++; if (drop !== 16'd0) begin errors++; $display("FAIL corner_drop got %0d want 0", drop); end
    $display("test_boundary: corner point (319,239)");
  endtask

  task automatic test_out_of_range();
    int base;
    base = beat_addr.size();
    drive_point(320, 0, 1);
    drive_point(0, 240, 2);
    repeat (3) tick();
    checks++; if (beat_addr.size() !== base) begin errors++; $display("FAIL oor_beats got %0d want 0", beat_addr.size() - base); end
    checks++; if (drop !== 16'd2) begin errors++; $display("FAIL oor_drop got %0d want 2", drop); end
    checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL oor_ovf got %0d want 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oor_busy got %b want 0", busy); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (drop !== 16'd0) begin errors++; $display("FAIL clr_drop got %0d want 0", drop); end
    checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL clr_ovf got %0d want 0", ovf); end
    $display("test_out_of_range done");
  endtask

  task automatic test_stall();
    int base;
    base = beat_addr.size();
    waitreq = 1'b1;
    drive_point(0, 0, 12'h123);                // N+1
    tick();                                    // N+2
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr !== 1'b1) begin errors++; $display("FAIL stall_write[%0d] got %b want 1", i, wr); end
      checks++; if (addr !== 17'd0) begin errors++; $display("FAIL stall_addr[%0d] got %0d want 0", i, addr); end
      checks++; if (wdata !== 16'h0123) begin errors++; $display("FAIL stall_data[%0d] got %h want 0123", i, wdata); end
      tick();
    end
    waitreq = 1'b0;                            // N+5: beat completes
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL stall_final_write got %b want 1", wr); end
    checks++; if (wdata !== 16'h0123) begin errors++; $display("FAIL stall_final_data got %h want 0123", wdata); end
    tick();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL stall_after_write got %b want 0", wr); end
    checks++; if (beat_addr.size() - base !== 1) begin errors++; $display("FAIL stall_beats got %0d want 1", beat_addr.size() - base); end
    $display("test_stall done");
  endtask

  task automatic test_back_to_back();
    int base;
    int waited;
    base = beat_addr.size();
    waitreq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      upd = 1'b1; px = 9'(k); py = 9'd0; rgb = 12'(k);
      tick();
    end
    upd = 1'b0;
    checks++; if (ovf !== 16'd1) begin errors++; $display("FAIL b2b_ovf got %0d want 1", ovf); end
    checks++; if (drop !== 16'd0) begin errors++; $display("FAIL b2b_drop got %0d want 0", drop); end
    waitreq = 1'b0;
    waited = 0;
    while (busy && waited < 40) begin
      tick();
      waited++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain_timeout busy got %b want 0", busy); end
    checks++; if (beat_addr.size() - base !== 9) begin errors++; $display("FAIL b2b_beats got %0d want 9", beat_addr.size() - base); end
    if (beat_addr.size() - base == 9) begin
      for (int k = 0; k < 9; k++) begin
        checks++; if (beat_addr[base+k] !== 17'(k)) begin errors++; $display("FAIL b2b_addr[%0d] got %0d want %0d", k, beat_addr[base+k], k); end
        checks++; if (beat_data[base+k] !== 16'(k)) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", k, beat_data[base+k], 16'(k)); end
        checks++; if (beat_cyc[base+k] !== beat_cyc[base] + k) begin errors++; $display("FAIL b2b_gap[%0d] got cycle %0d want %0d", k, beat_cyc[base+k], beat_cyc[base] + k); end
      end
    end
    $display("test_back_to_back: %0d beats", beat_addr.size() - base);
  endtask

  task automatic test_reset_mid();
    int base;
    base = beat_addr.size();
    waitreq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      upd = 1'b1; px = 9'(k + 20); py = 9'd3; rgb = 12'h5A5;
      tick();
    end
    upd = 1'b0;
    tick();
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL rstmid_pre_write got %b want 1", wr); end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rstmid_write got %b want 0", wr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (addr !== 17'd0) begin errors++; $display("FAIL rstmid_addr got %0d want 0", addr); end
    checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL rstmid_ovf got %0d want 0", ovf); end
    waitreq = 1'b0;
    repeat (10) tick();
    checks++; if (beat_addr.size() !== base) begin errors++; $display("FAIL rstmid_beats got %0d want 0", beat_addr.size() - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
    $display("test_reset_mid done");
  endtask

  task automatic test_clear_priority();
    drive_point(400, 0, 0);
    checks++; if (drop !== 16'd1) begin errors++; $display("FAIL clrpri_pre got %0d want 1", drop); end
    clr = 1'b1;
    drive_point(400, 0, 0);
    clr = 1'b0;
    checks++; if (drop !== 16'd0) begin errors++; $display("FAIL clrpri_drop got %0d want 0", drop); end
    $display("test_clear_priority done");
  endtask

  task automatic test_saturation();
    int base;
    base = beat_addr.size();
    upd = 1'b1; px = 9'd500; py = 9'd0; rgb = 12'h0;
    repeat (65535) tick();
    checks++; if (drop !== 16'hFFFF) begin errors++; $display("FAIL sat_65535 got %h want ffff", drop); end
    tick();
    checks++; if (drop !== 16'hFFFF) begin errors++; $display("FAIL sat_65536 got %h want ffff", drop); end
    tick();
    upd = 1'b0;
    checks++; if (drop !== 16'hFFFF) begin errors++; $display("FAIL sat_65537 got %h want ffff", drop); end
    checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL sat_ovf got %0d want 0", ovf); end
    checks++; if (beat_addr.size() !== base) begin errors++; $display("FAIL sat_beats got %0d want 0", beat_addr.size() - base); end
    $display("test_saturation: drop=%h", drop);
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_out_of_range();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_clear_priority();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
